// File: rtl/eeprom_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : eeprom_cmd_sequencer
//  Description : Turns one host request (READ / WRITE / ERASE at a 6-bit
//                address) into the AT93C46D engine transactions it needs:
//                EWEN -> op -> program wait -> EWDS for WRITE/ERASE, a single
//                READ for reads. Tracks engine completion from spi_cs and
//                returns read data and status to the host.
//  Ports       :
//    clk, rst            - clock, synchronous active-high reset
//    req/op/addr/wdata   - host request (sampled only when ready)
//    ready/done/err      - host handshake and status (done is a 1-cycle pulse)
//    rdata               - read data, updated only on a successful READ
//    spi_cmd/spi_data_in - engine command {opcode, address} and write data
//    spi_start           - engine start (single-cycle pulse)
//    spi_cs/spi_data_out - engine busy indication and read data
//  Revision    : 1.0 - initial release
// ============================================================================
module eeprom_cmd_sequencer #(
    parameter int GAP_CYCLES     = 64,
    parameter int PROG_CYCLES    = 1250000,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [1:0]  op,
    input  logic [5:0]  addr,
    input  logic [15:0] wdata,
    output logic        ready,
    output logic        done,
    output logic        err,
    output logic [15:0] rdata,
    output logic [7:0]  spi_cmd,
    output logic [15:0] spi_data_in,
    output logic        spi_start,
    input  logic        spi_cs,
    input  logic [15:0] spi_data_out
);

    // One counter serves GAP, PROG_WAIT and the transfer timeout; they are
    // never active at the same time, so it is sized for the largest.
    localparam int c_MAX_GP  = (GAP_CYCLES > PROG_CYCLES) ? GAP_CYCLES : PROG_CYCLES;
    localparam int c_MAX_ALL = (c_MAX_GP > TIMEOUT_CYCLES) ? c_MAX_GP : TIMEOUT_CYCLES;
    localparam int c_CNT_W   = ($clog2(c_MAX_ALL + 1) < 1) ? 1 : $clog2(c_MAX_ALL + 1);

    // Terminal counts; a zero parameter still gives a one-cycle state.
    localparam logic [c_CNT_W-1:0] c_GAP_LAST  = c_CNT_W'((GAP_CYCLES     == 0) ? 0 : GAP_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_PROG_LAST = c_CNT_W'((PROG_CYCLES    == 0) ? 0 : PROG_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_TO_LAST   = c_CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    localparam logic [1:0] c_OP_RSVD  = 2'b00;
    localparam logic [1:0] c_OP_WRITE = 2'b01;
    localparam logic [1:0] c_OP_READ  = 2'b10;
    localparam logic [7:0] c_CMD_EWEN = 8'b0011_0000;
    localparam logic [7:0] c_CMD_EWDS = 8'b0000_0000;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_EWEN_X    = 3'd1,
        S_OP_X      = 3'd2,
        S_PROG_WAIT = 3'd3,
        S_EWDS_X    = 3'd4,
        S_DONE      = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        X_SETUP   = 3'd0,
        X_ISSUE   = 3'd1,
        X_WAIT_HI = 3'd2,
        X_WAIT_LO = 3'd3,
        X_GAP     = 3'd4
    } xfer_t;

    state_t               r_state;
    xfer_t                r_xfer;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [1:0]           r_op;
    logic [5:0]           r_addr;
    logic [15:0]          r_wdata;
    logic                 r_ready;
    logic                 r_done;
    logic                 r_err;
    logic [15:0]          r_rdata;
    logic [7:0]           r_spi_cmd;
    logic [15:0]          r_spi_din;
    logic                 r_spi_start;

    logic [7:0]           w_cmd;
    logic [15:0]          w_din;
    state_t               w_after;
    state_t               w_abort;

    // Command/data for the transfer owned by the current top-level state,
    // the state that follows a clean transfer, and the state after a timeout.
    always_comb begin
        w_cmd   = c_CMD_EWDS;
        w_din   = 16'h0000;
        w_after = S_DONE;
        w_abort = S_DONE;
        case (r_state)
            S_EWEN_X: begin
                w_cmd   = c_CMD_EWEN;
                w_after = S_OP_X;
            end
            S_OP_X: begin
                w_cmd   = {r_op, r_addr};
                if (r_op == c_OP_WRITE) begin
                    w_din = r_wdata;
                end
                w_after = (r_op == c_OP_READ) ? S_DONE : S_PROG_WAIT;
            end
            default: ;
        endcase
        // Write enable may have been left on: always try to close with EWDS.
        if ((r_op != c_OP_READ) && (r_state != S_EWDS_X)) begin
            w_abort = S_EWDS_X;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_xfer      <= X_SETUP;
            r_cnt       <= '0;
            r_op        <= 2'b00;
            r_addr      <= 6'h00;
            r_wdata     <= 16'h0000;
            r_ready     <= 1'b1;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_rdata     <= 16'h0000;
            r_spi_cmd   <= 8'h00;
            r_spi_din   <= 16'h0000;
            r_spi_start <= 1'b0;
        end else begin
            r_spi_start <= 1'b0;
            r_done      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req && r_ready) begin
                        r_op    <= op;
                        r_addr  <= addr;
                        r_wdata <= wdata;
                        r_ready <= 1'b0;
                        r_err   <= 1'b0;
                        r_cnt   <= '0;
                        r_xfer  <= X_SETUP;
                        if (op == c_OP_RSVD) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
                        end else if (op == c_OP_READ) begin
                            r_state <= S_OP_X;
                        end else begin
                            r_state <= S_EWEN_X;
                        end
                    end
                end

                S_EWEN_X, S_OP_X, S_EWDS_X: begin
                    case (r_xfer)
                        X_SETUP: begin
                            r_spi_cmd <= w_cmd;
                            r_spi_din <= w_din;
                            r_cnt     <= '0;
                            r_xfer    <= X_ISSUE;
                        end
                        X_ISSUE: begin
                            // Hold off the start edge while the engine is
                            // still selected (only possible after a timeout).
                            if (!spi_cs) begin
                                r_spi_start <= 1'b1;
                                r_xfer      <= X_WAIT_HI;
                            end else if (r_cnt >= c_TO_LAST) begin
                                r_err   <= 1'b1;
                                r_cnt   <= '0;
                                r_xfer  <= X_SETUP;
                                r_state <= w_abort;
                                r_done  <= (w_abort == S_DONE);
                            end else begin
                                r_cnt <= r_cnt + 1'b1;
                            end
                        end
                        X_WAIT_HI, X_WAIT_LO: begin
                            // The timeout counter runs across both phases.
                            if ((r_xfer == X_WAIT_HI) && spi_cs) begin
                                r_cnt  <= r_cnt + 1'b1;
                                r_xfer <= X_WAIT_LO;
                            end else if ((r_xfer == X_WAIT_LO) && !spi_cs) begin
                                if ((r_state == S_OP_X) && (r_op == c_OP_READ)) begin
                                    r_rdata <= spi_data_out;
                                end
                                r_cnt  <= '0;
                                r_xfer <= X_GAP;
                            end else if (r_cnt >= c_TO_LAST) begin
                                r_err   <= 1'b1;
                                r_cnt   <= '0;
                                r_xfer  <= X_SETUP;
                                r_state <= w_abort;
                                r_done  <= (w_abort == S_DONE);
                            end else begin
                                r_cnt <= r_cnt + 1'b1;
                            end
                        end
                        X_GAP: begin
                            if (r_cnt >= c_GAP_LAST) begin
                                r_cnt   <= '0;
                                r_xfer  <= X_SETUP;
                                r_state <= w_after;
                                r_done  <= (w_after == S_DONE);
                            end else begin
                                r_cnt <= r_cnt + 1'b1;
                            end
                        end
                        default: r_xfer <= X_SETUP;
                    endcase
                end

                S_PROG_WAIT: begin
                    if (r_cnt >= c_PROG_LAST) begin
                        r_cnt   <= '0;
                        r_xfer  <= X_SETUP;
                        r_state <= S_EWDS_X;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                S_DONE: begin
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign ready       = r_ready;
    assign done        = r_done;
    assign err         = r_err;
    assign rdata       = r_rdata;
    assign spi_cmd     = r_spi_cmd;
    assign spi_data_in = r_spi_din;
    assign spi_start   = r_spi_start;

endmodule
`default_nettype wire

// File: tb/tb_eeprom_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_eeprom_cmd_sequencer
//  Description : Self-checking bench for eeprom_cmd_sequencer. A small engine
//                model answers start pulses; expected engine transactions and
//                host results are queued as requests are driven and compared
//                when the DUT produces them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_eeprom_cmd_sequencer;

    localparam int GAP     = 4;
    localparam int PROG    = 20;
    localparam int TIMEOUT = 40;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [5:0]  addr = 6'h00;
    logic [15:0] wdata = 16'h0000;
    logic        ready, done, err;
    logic [15:0] rdata;
    logic [7:0]  spi_cmd;
    logic [15:0] spi_data_in;
    logic        spi_start;
    logic        spi_cs = 1'b0;
    logic [15:0] spi_data_out = 16'h0000;

    eeprom_cmd_sequencer #(
        .GAP_CYCLES     (GAP),
        .PROG_CYCLES    (PROG),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .op           (op),
        .addr         (addr),
        .wdata        (wdata),
        .ready        (ready),
        .done         (done),
        .err          (err),
        .rdata        (rdata),
        .spi_cmd      (spi_cmd),
        .spi_data_in  (spi_data_in),
        .spi_start    (spi_start),
        .spi_cs       (spi_cs),
        .spi_data_out (spi_data_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  cmd;
        logic [15:0] din;
        int          min_gap;
    } tx_t;

    typedef struct {
        logic        err;
        logic [15:0] rdata;
        int          lat_lo;   // -1: latency not checked
        int          lat_hi;
    } res_t;

    tx_t  exp_tx[$];
    res_t exp_res[$];

    int n_vec = 0;
    int n_err = 0;
    int n_done = 0;
    int cyc = 0;
    int accept_cyc = 0;
    int since_lo = 1000;
    logic prev_start = 1'b0;

    logic        eng_dead = 1'b0;
    logic [15:0] eng_rdata = 16'h0000;
    logic        eng_busy = 1'b0;
    int          eng_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_vec++;
        assert (got === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, expv);
        end
    endtask

    // Engine model: cs rises the cycle after start is seen, stays high for
    // four cycles, and read data is presented as cs falls.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            eng_busy <= 1'b0;
            eng_cnt  <= 0;
            spi_cs   <= 1'b0;
        end else if (eng_busy) begin
            eng_cnt <= eng_cnt + 1;
            if (eng_cnt == 0) spi_cs <= 1'b1;
            if (eng_cnt == 4) begin
                spi_cs       <= 1'b0;
                spi_data_out <= eng_rdata;
                eng_busy     <= 1'b0;
            end
        end else if (spi_start && !eng_dead) begin
            eng_busy <= 1'b1;
            eng_cnt  <= 0;
        end
    end

    // Monitors: transactions, done pulses, start/cs exclusion.
    always @(negedge clk) begin
        tx_t  et;
        res_t er;
        if (!rst) begin
            check("start_while_cs", 32'(spi_start & spi_cs), 32'd0);
            if (spi_start && !prev_start) begin
                if (exp_tx.size() == 0) begin
                    check("unexpected_start", 32'd1, 32'd0);
                end else begin
                    et = exp_tx.pop_front();
                    check("tx_cmd", 32'(spi_cmd), 32'(et.cmd));
                    check("tx_data_in", 32'(spi_data_in), 32'(et.din));
                    check("tx_gap_ok", 32'(since_lo >= et.min_gap), 32'd1);
                end
            end
            if (done) begin
                n_done++;
                if (exp_res.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    er = exp_res.pop_front();
                    check("done_err", 32'(err), 32'(er.err));
                    check("done_rdata", 32'(rdata), 32'(er.rdata));
                    if (er.lat_lo >= 0) begin
                        check("done_latency_ok",
                              32'(((cyc - accept_cyc) >= er.lat_lo) && ((cyc - accept_cyc) <= er.lat_hi)),
                              32'd1);
                    end
                end
            end
        end
        prev_start <= spi_start;
        since_lo   <= spi_cs ? 0 : since_lo + 1;
    end

    task automatic do_req(input logic [1:0] o, input logic [5:0] a, input logic [15:0] d);
        int guard = 0;
        @(negedge clk);
        req = 1'b1; op = o; addr = a; wdata = d;
        while (!ready && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        check("req_ready", 32'(ready), 32'd1);
        accept_cyc = cyc;
        @(negedge clk);
        // Scramble host inputs: the DUT must use only the latched copy.
        req = 1'b0; op = 2'($urandom); addr = 6'($urandom); wdata = 16'($urandom);
        check("ready_drop", 32'(ready), 32'd0);
    endtask

    task automatic wait_done(input int budget, input string tag);
        int start_cnt = n_done;
        int i = 0;
        while (n_done == start_cnt && i < budget) begin
            @(posedge clk);
            #1;
            i++;
        end
        check(tag, 32'(n_done != start_cnt), 32'd1);
    endtask

    task automatic check_reset_outputs();
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        check("rst_spi_cmd", 32'(spi_cmd), 32'd0);
        check("rst_spi_data_in", 32'(spi_data_in), 32'd0);
        check("rst_spi_start", 32'(spi_start), 32'd0);
    endtask

    initial begin
        int guard;
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs();
        rst = 1'b0;

        // READ 0x15 -> 0xBEEF
        eng_rdata = 16'hBEEF;
        exp_tx.push_back('{8'h95, 16'h0000, GAP});
        exp_res.push_back('{1'b0, 16'hBEEF, -1, 0});
        do_req(2'b10, 6'h15, 16'h0000);
        wait_done(100, "read_done");

        // WRITE 0x03 / 0x1234; engine data_out must not reach rdata
        eng_rdata = 16'hDEAD;
        exp_tx.push_back('{8'h30, 16'h0000, GAP});
        exp_tx.push_back('{8'h43, 16'h1234, GAP});
        exp_tx.push_back('{8'h00, 16'h0000, GAP + PROG});
        exp_res.push_back('{1'b0, 16'hBEEF, -1, 0});
        do_req(2'b01, 6'h03, 16'h1234);
        wait_done(200, "write_done");

        // ERASE 0x3F with non-zero wdata presented: data_in must be 0
        exp_tx.push_back('{8'h30, 16'h0000, GAP});
        exp_tx.push_back('{8'hFF, 16'h0000, GAP});
        exp_tx.push_back('{8'h00, 16'h0000, GAP + PROG});
        exp_res.push_back('{1'b0, 16'hBEEF, -1, 0});
        do_req(2'b11, 6'h3F, 16'hA5A5);
        wait_done(200, "erase_done");

        // READ with a dead engine: timeout, rdata unchanged
        eng_dead = 1'b1;
        exp_tx.push_back('{8'h8A, 16'h0000, GAP});
        exp_res.push_back('{1'b1, 16'hBEEF, TIMEOUT, TIMEOUT + 5});
        do_req(2'b10, 6'h0A, 16'h0000);
        wait_done(TIMEOUT + 30, "read_timeout_done");

        // WRITE with a dead engine: EWEN times out, EWDS still attempted
        exp_tx.push_back('{8'h30, 16'h0000, GAP});
        exp_tx.push_back('{8'h00, 16'h0000, 0});
        exp_res.push_back('{1'b1, 16'hBEEF, -1, 0});
        do_req(2'b01, 6'h07, 16'h7777);
        wait_done(3 * TIMEOUT + 50, "write_timeout_done");
        eng_dead = 1'b0;

        // Reserved op: done on the next cycle with err, no start
        exp_res.push_back('{1'b1, 16'hBEEF, 1, 1});
        do_req(2'b00, 6'h11, 16'h0000);
        wait_done(10, "rsvd_done");

        // req held high: two back-to-back READs, err cleared on accept
        eng_rdata = 16'h5A5A;
        exp_tx.push_back('{8'hA1, 16'h0000, GAP});
        exp_tx.push_back('{8'hA1, 16'h0000, GAP});
        exp_res.push_back('{1'b0, 16'h5A5A, -1, 0});
        exp_res.push_back('{1'b0, 16'h5A5A, -1, 0});
        @(negedge clk);
        req = 1'b1; op = 2'b10; addr = 6'h21;
        wait_done(100, "held_done_1");
        wait_done(100, "held_done_2");
        req = 1'b0;

        // Reset during PROG_WAIT of a WRITE: no EWDS afterwards
        eng_rdata = 16'h0BAD;
        exp_tx.push_back('{8'h30, 16'h0000, GAP});
        exp_tx.push_back('{8'h50, 16'hCAFE, GAP});
        do_req(2'b01, 6'h10, 16'hCAFE);
        guard = 0;
        while (exp_tx.size() != 0 && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("prog_reached", 32'(exp_tx.size()), 32'd0);
        repeat (16) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs();
        rst = 1'b0;
        exp_tx.delete();
        repeat (40) @(negedge clk);

        // Recovery READ 0x00
        eng_rdata = 16'h0001;
        exp_tx.push_back('{8'h80, 16'h0000, GAP});
        exp_res.push_back('{1'b0, 16'h0001, -1, 0});
        do_req(2'b10, 6'h00, 16'h0000);
        wait_done(100, "recover_done");

        repeat (5) @(negedge clk);
        check("tx_queue_empty", 32'(exp_tx.size()), 32'd0);
        check("res_queue_empty", 32'(exp_res.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/eeprom_cmd_sequencer.md
Name: eeprom_cmd_sequencer

Overview:
- Sequences the AT93C46D 3-wire SPI engine on behalf of a single host requester (register bank / CPU bridge).
- Turns one host request (READ, WRITE or ERASE at a 6-bit address) into the required engine transactions: EWEN → op → program-wait → EWDS for WRITE/ERASE; a single READ for reads.
- Drives the engine's cmd/data_in/start inputs, tracks transaction completion from the engine's cs output, and returns read data and status to the host.

Parameters:
- GAP_CYCLES, 64, idle clk cycles enforced between consecutive engine transactions (cs deselect time).
- PROG_CYCLES, 1250000, clk cycles waited after a WRITE/ERASE transaction before issuing EWDS (tWP, 10 ms at 125 MHz).
- TIMEOUT_CYCLES, 65536, maximum clk cycles allowed for a start pulse to produce cs high and for cs to return low.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- req  in  1  host request; sampled only in IDLE.
- op  in  2  01 = WRITE, 10 = READ, 11 = ERASE; 00 is reserved and rejected.
- addr  in  6  EEPROM word address.
- wdata  in  16  write data.
- ready  out  1  high in IDLE; a request is accepted when req & ready.
- done  out  1  one-cycle pulse at the end of a sequence.
- err  out  1  valid with done: timeout or reserved op.
- rdata  out  16  read data; updated only on a successful READ done.
- spi_cmd  out  8  to engine cmd: [7:6] opcode, [5:0] address.
- spi_data_in  out  16  to engine data_in.
- spi_start  out  1  to engine start (engine is rising-edge triggered).
- spi_cs  in  1  engine cs output; high means a transaction is in progress.
- spi_data_out  in  16  engine data_out; valid once cs has fallen after a READ.

Behaviour:
- Reset values:
  - ready = 1; done = 0; err = 0; rdata = 0.
  - spi_cmd = 0; spi_data_in = 0; spi_start = 0.
  - FSM state = IDLE; all counters cleared.
- Reset mid-sequence returns to IDLE immediately with no EWDS issued. The host is responsible for re-issuing.
- Request capture: on accept, latch op, addr and wdata; ready drops the next cycle. Later changes to the host inputs have no effect until the next IDLE.
- Command encodings on spi_cmd:
  - EWEN = 8'b0011_0000.
  - EWDS = 8'b0000_0000.
  - WRITE = {2'b01, addr}.
  - READ = {2'b10, addr}.
  - ERASE = {2'b11, addr}.
- spi_data_in = latched wdata for WRITE, 0 otherwise.
- Transaction subsequence (XFER), used for every command:
  - ISSUE: spi_cmd/spi_data_in are already stable; spi_start = 1 for exactly 1 cycle.
  - WAIT_HI: wait for spi_cs = 1.
  - WAIT_LO: wait for spi_cs = 0.
  - GAP: count GAP_CYCLES with spi_start = 0.
  - spi_cmd and spi_data_in are set one cycle before ISSUE and held until GAP ends.
  - A single timeout counter covers WAIT_HI plus WAIT_LO. If it reaches TIMEOUT_CYCLES, go to DONE with err = 1.
- Top-level states: IDLE, EWEN_X, OP_X, PROG_WAIT, EWDS_X, DONE. Each _X state runs the XFER subsequence.
- Transitions:
  - IDLE → DONE with err = 1 if op = 00.
  - IDLE → OP_X for READ.
  - IDLE → EWEN_X for WRITE/ERASE.
  - EWEN_X → OP_X.
  - OP_X → DONE for READ; on WAIT_LO exit, rdata <= spi_data_out.
  - OP_X → PROG_WAIT for WRITE/ERASE.
  - PROG_WAIT (counts PROG_CYCLES) → EWDS_X → DONE.
  - DONE: done = 1 for 1 cycle, then IDLE with ready = 1.
  - If a timeout occurs in EWEN_X or OP_X of a WRITE/ERASE, still run EWDS_X before DONE (best effort). err stays set. A timeout inside EWDS_X goes straight to DONE.
- err is cleared when the next request is accepted.
- spi_start never rises while spi_cs = 1.
- Counters: all counter widths are sized to cover their parameter. Count k runs 0..k-1 then advances. GAP_CYCLES = 0 or PROG_CYCLES = 0 means that state lasts exactly 1 cycle.
- Latency: READ done pulse = 1 (accept) + 2 + T_engine + GAP_CYCLES + 1 cycles, where T_engine is the engine cs-high duration.

Test Plan:
- READ addr=0x15, engine model returns 0xBEEF → spi_cmd=0x95, one start pulse, exactly 1 transaction; done with err=0, rdata=0xBEEF.
- WRITE addr=0x03 wdata=0x1234 → transaction order EWEN (0x30), WRITE (0x43, data 0x1234), PROG_CYCLES wait, EWDS (0x00); gaps ≥ GAP_CYCLES; rdata unchanged.
- ERASE addr=0x3F → EWEN, 0xFF, wait, EWDS; done with err=0; spi_data_in=0 during ERASE.
- Engine model never raises cs on a READ → err=1 with done after TIMEOUT_CYCLES+1 cycles. Same for a WRITE: EWDS start is still attempted.
- op=00 → done on the next cycle with err=1, no spi_start pulse. Assert rst mid-PROG_WAIT → all outputs at reset values on the next cycle, ready=1.
- req held high continuously → the next sequence starts only after done; spi_start never asserted while spi_cs=1 (assertion).
